tetris_line_clear: RTL

//  Parametrised playfield store plus line-clear engine for the tetris core. Holds the

---
 rtl/tetris_line_clear_if.sv | 36 +++
 rtl/tetris_line_clear.sv | 184 ++++++++++++++++++
 2 files changed

// File: rtl/tetris_line_clear_if.sv
// Bus bundle between the tile datapath / display and the playfield store.
//   master: tile datapath + display side (drives commits, start, read address)
//   slave : tetris_line_clear (drives status, pass results, read data)
// Signals:
//   ready_o, done_o, lines_o, lines_total_o, top_out_o, rd_data_o   board -> datapath
//   commit_v_i, commit_row_i, commit_mask_i, start_i, rd_row_i      datapath -> board
interface tetris_line_clear_if #(
  parameter int unsigned width_p       = 16,
  parameter int unsigned height_p      = 16,
  parameter int unsigned count_width_p = 16
) ();
  localparam int unsigned RowW   = $clog2(height_p);
  localparam int unsigned LinesW = RowW + 1;

  logic                     ready_o;
  logic                     commit_v_i;
  logic [RowW-1:0]          commit_row_i;
  logic [width_p-1:0]       commit_mask_i;
  logic                     start_i;
  logic                     done_o;
  logic [LinesW-1:0]        lines_o;
  logic [count_width_p-1:0] lines_total_o;
  logic                     top_out_o;
  logic [RowW-1:0]          rd_row_i;
  logic [width_p-1:0]       rd_data_o;

  modport master (
    input  ready_o, done_o, lines_o, lines_total_o, top_out_o, rd_data_o,
    output commit_v_i, commit_row_i, commit_mask_i, start_i, rd_row_i
  );

  modport slave (
    output ready_o, done_o, lines_o, lines_total_o, top_out_o, rd_data_o,
    input  commit_v_i, commit_row_i, commit_mask_i, start_i, rd_row_i
  );
endinterface

// File: rtl/tetris_line_clear.sv
// Playfield store plus line-clear engine.
// Holds a height_p x width_p occupancy board (row 0 top). In IDLE, committed tile rows are
// ORed in and a clear pass may be started. A pass scans bottom-up, drops full rows, copies
// the survivors down and zero-fills the rows left at the top, then pulses done_o with the
// number of rows removed.
// Ports:
//   clk_i, reset_i   clock and synchronous active-high reset
//   bus (slave)      commit/start inputs, ready/done/lines/total/top_out status, display read
//   score_o          running score, only present when TETRIS_SCORE_EN is defined
// Build option: define TETRIS_SCORE_EN to add the score_o port and its adder.
module tetris_line_clear #(
  parameter int unsigned width_p       = 16,
  parameter int unsigned height_p      = 16,
  parameter int unsigned count_width_p = 16
) (
  input  logic              clk_i,
  input  logic              reset_i,
  tetris_line_clear_if.slave bus
`ifdef TETRIS_SCORE_EN
  ,
  output logic [count_width_p-1:0] score_o
`endif
);
  localparam int unsigned RowW   = $clog2(height_p);
  localparam int unsigned LinesW = RowW + 1;
  // Wide enough for count + 1200 without overflow, so saturation is a plain compare.
  localparam int unsigned SumW   = ((count_width_p > 11) ? count_width_p : 11) + 1;

  localparam logic [1:0] StIdle = 2'd0;
  localparam logic [1:0] StScan = 2'd1;
  localparam logic [1:0] StFill = 2'd2;
  localparam logic [1:0] StDone = 2'd3;

  localparam logic [RowW-1:0]          LastRow  = RowW'(height_p - 1);
  localparam logic [width_p-1:0]       FullRow  = '1;
  localparam logic [count_width_p-1:0] CountMax = '1;

  logic [1:0]               state_q, state_d;
  logic [RowW-1:0]          r_q, r_d;
  logic [RowW-1:0]          w_q, w_d;
  logic [LinesW-1:0]        k_q, k_d;
  logic [width_p-1:0]       board_q [height_p];
  logic [width_p-1:0]       board_d [height_p];
  logic [LinesW-1:0]        lines_q, lines_d;
  logic [count_width_p-1:0] total_q, total_d;
  logic                     top_q, top_d;
  logic                     enter_done;
  logic                     commit_ok;
  logic [SumW-1:0]          total_sum;

  assign commit_ok = bus.commit_v_i && ({1'b0, bus.commit_row_i} < LinesW'(height_p));
  assign total_sum = SumW'(total_q) + SumW'(k_d);

  always_comb begin
    state_d    = state_q;
    r_d        = r_q;
    w_d        = w_q;
    k_d        = k_q;
    board_d    = board_q;
    lines_d    = lines_q;
    total_d    = total_q;
    top_d      = top_q;
    enter_done = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (commit_ok) begin
          board_d[bus.commit_row_i] = board_q[bus.commit_row_i] | bus.commit_mask_i;
        end
        if (bus.start_i) begin
          r_d     = LastRow;
          w_d     = LastRow;
          k_d     = '0;
          state_d = StScan;
        end
      end
      StScan: begin
        if (board_q[r_q] == FullRow) begin
          k_d = k_q + 1'b1;
        end else begin
          // Survivors only move once a full row below them has been skipped.
          if (w_q != r_q) begin
            board_d[w_q] = board_q[r_q];
          end
          w_d = w_q - 1'b1;
        end
        r_d = r_q - 1'b1;
        if (r_q == '0) begin
          if (k_d != '0) begin
            state_d = StFill;
          end else begin
            state_d    = StDone;
            enter_done = 1'b1;
          end
        end
      end
      StFill: begin
        // w ends the scan at k-1, so filling down to row 0 takes exactly k cycles.
        board_d[w_q] = '0;
        w_d          = w_q - 1'b1;
        if (w_q == '0) begin
          state_d    = StDone;
          enter_done = 1'b1;
        end
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase

    // Results are latched on the edge into DONE so they are visible alongside done_o.
    if (enter_done) begin
      lines_d = k_d;
      total_d = (total_sum > SumW'(CountMax)) ? CountMax : total_sum[count_width_p-1:0];
      top_d   = |board_d[0];
    end else if (state_q == StIdle && commit_ok) begin
      top_d = |board_d[0];
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q <= StIdle;
      r_q     <= '0;
      w_q     <= '0;
      k_q     <= '0;
      board_q <= '{default: '0};
      lines_q <= '0;
      total_q <= '0;
      top_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      r_q     <= r_d;
      w_q     <= w_d;
      k_q     <= k_d;
      board_q <= board_d;
      lines_q <= lines_d;
      total_q <= total_d;
      top_q   <= top_d;
    end
  end

`ifdef TETRIS_SCORE_EN
  logic [count_width_p-1:0] score_q, score_d;
  logic [10:0]              score_inc;
  logic [SumW-1:0]          score_sum;

  always_comb begin
    case (k_d)
      LinesW'(0): score_inc = 11'd0;
      LinesW'(1): score_inc = 11'd40;
      LinesW'(2): score_inc = 11'd100;
      LinesW'(3): score_inc = 11'd300;
      default:    score_inc = 11'd1200;
    endcase
    score_sum = SumW'(score_q) + SumW'(score_inc);
    score_d   = score_q;
    if (enter_done) begin
      score_d = (score_sum > SumW'(CountMax)) ? CountMax : score_sum[count_width_p-1:0];
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      score_q <= '0;
    end else begin
      score_q <= score_d;
    end
  end

  assign score_o = score_q;
`endif

  assign bus.ready_o       = (state_q == StIdle);
  assign bus.done_o        = (state_q == StDone);
  assign bus.lines_o       = lines_q;
  assign bus.lines_total_o = total_q;
  assign bus.top_out_o     = top_q;
  assign bus.rd_data_o     = ({1'b0, bus.rd_row_i} < LinesW'(height_p)) ? board_q[bus.rd_row_i]
                                                                         : '0;
endmodule
